// File: rtl/ub_row_writer.sv
// Unified-buffer row writer: de-skews four activation columns in
// per-column FIFOs and writes packed 64-bit rows at consecutive addresses.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_in          pulse: latch base_addr_in / num_rows_in
//   col_valid_k_in    per-column push strobe (k = 1..4)
//   col_data_k_in     per-column value, signed, passed through
//   ub_wr_en_out      write request, held until ub_wr_ready_in
//   ub_wr_addr_out    write address
//   ub_wr_data_out    packed row, col1 in the LSBs
//   ub_wr_ready_in    buffer accepts the write this cycle
//   busy_out          collecting rows
//   done_out          one-cycle completion pulse
//   overflow_out      sticky: a column value was dropped
module ub_row_writer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_in,
  input  logic [ADDR_W-1:0]   base_addr_in,
  input  logic [ADDR_W-1:0]   num_rows_in,
  input  logic                col_valid_1_in,
  input  logic                col_valid_2_in,
  input  logic                col_valid_3_in,
  input  logic                col_valid_4_in,
  input  logic [DATA_W-1:0]   col_data_1_in,
  input  logic [DATA_W-1:0]   col_data_2_in,
  input  logic [DATA_W-1:0]   col_data_3_in,
  input  logic [DATA_W-1:0]   col_data_4_in,
  output logic                ub_wr_en_out,
  output logic [ADDR_W-1:0]   ub_wr_addr_out,
  output logic [4*DATA_W-1:0] ub_wr_data_out,
  input  logic                ub_wr_ready_in,
  output logic                busy_out,
  output logic                done_out,
  output logic                overflow_out
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FINISH
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [4][FIFO_DEPTH];
  logic [PW:0]       wp [4];
  logic [PW:0]       rp [4];
  logic [DATA_W-1:0] din [4];
  logic [3:0]        vld;
  logic [3:0]        empty;
  logic [3:0]        full;
  logic [3:0]        push;
  logic [ADDR_W-1:0] rows_left;
  logic [ADDR_W-1:0] load_left;
  logic              accept;
  logic              pop;
  logic              xfer;
  logic              out_free;
  logic              drop;

  always_comb begin
    vld    = {col_valid_4_in, col_valid_3_in,
              col_valid_2_in, col_valid_1_in};
    din[0] = col_data_1_in;
    din[1] = col_data_2_in;
    din[2] = col_data_3_in;
    din[3] = col_data_4_in;
    // once every row has been loaded, further column data is surplus
    accept   = (state == COLLECT) && (load_left != '0);
    xfer     = ub_wr_en_out && ub_wr_ready_in;
    out_free = !ub_wr_en_out || ub_wr_ready_in;
    for (int k = 0; k < 4; k++) begin
      empty[k] = (wp[k] == rp[k]);
      full[k]  = (wp[k][PW] != rp[k][PW]) &&
                 (wp[k][PW-1:0] == rp[k][PW-1:0]);
    end
    pop  = accept && (empty == 4'b0000) && out_free;
    drop = accept && !pop && ((vld & full) != 4'b0000);
    for (int k = 0; k < 4; k++) begin
      // a full FIFO still takes a push when it pops on the same edge
      push[k] = accept && vld[k] && (!full[k] || pop);
    end
  end

  assign busy_out = (state == COLLECT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ub_wr_en_out   <= 1'b0;
      ub_wr_addr_out <= '0;
      ub_wr_data_out <= '0;
      done_out       <= 1'b0;
      overflow_out   <= 1'b0;
      rows_left      <= '0;
      load_left      <= '0;
      for (int k = 0; k < 4; k++) begin
        wp[k] <= '0;
        rp[k] <= '0;
      end
    end else begin
      done_out <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (push[k]) begin
          mem[k][wp[k][PW-1:0]] <= din[k];
          wp[k] <= wp[k] + 1'b1;
        end
        if (pop) rp[k] <= rp[k] + 1'b1;
      end
      if (drop) overflow_out <= 1'b1;
      if (pop) begin
        ub_wr_en_out   <= 1'b1;
        ub_wr_data_out <= {mem[3][rp[3][PW-1:0]],
                           mem[2][rp[2][PW-1:0]],
                           mem[1][rp[1][PW-1:0]],
                           mem[0][rp[0][PW-1:0]]};
        load_left <= load_left - 1'b1;
      end else if (xfer) begin
        ub_wr_en_out <= 1'b0;
      end
      if (xfer) begin
        ub_wr_addr_out <= ub_wr_addr_out + 1'b1;
        rows_left      <= rows_left - 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start_in) begin
            overflow_out <= 1'b0;
            if (num_rows_in != '0) begin
              ub_wr_addr_out <= base_addr_in;
              rows_left      <= num_rows_in;
              load_left      <= num_rows_in;
              state          <= COLLECT;
            end else begin
              done_out <= 1'b1;
              state    <= FINISH;
            end
          end
        end
        COLLECT: begin
          if (xfer && rows_left == ADDR_W'(1)) begin
            done_out <= 1'b1;
            state    <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
          // discard anything left over from surplus pushes
          for (int k = 0; k < 4; k++) begin
            wp[k] <= '0;
            rp[k] <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ub_row_writer.sv
// Bench for ub_row_writer: directed steps with a write scoreboard.
// Inputs change 1ns after posedge; the monitor samples at negedge.
module tb_ub_row_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base = '0;
  logic [7:0]  nrows = '0;
  logic        cv1 = 0, cv2 = 0, cv3 = 0, cv4 = 0;
  logic [15:0] cd1 = '0, cd2 = '0, cd3 = '0, cd4 = '0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic        ready = 1'b0;
  logic        busy, done, ovf;

  int total = 0;
  int bad = 0;
  int writes = 0;
  int done_cnt = 0;
  logic [71:0] sb [$];

  always #5 clk = ~clk;

  ub_row_writer dut (
    .clk(clk), .rst(rst), .start_in(start),
    .base_addr_in(base), .num_rows_in(nrows),
    .col_valid_1_in(cv1), .col_valid_2_in(cv2),
    .col_valid_3_in(cv3), .col_valid_4_in(cv4),
    .col_data_1_in(cd1), .col_data_2_in(cd2),
    .col_data_3_in(cd3), .col_data_4_in(cd4),
    .ub_wr_en_out(wr_en), .ub_wr_addr_out(wr_addr),
    .ub_wr_data_out(wr_data), .ub_wr_ready_in(ready),
    .busy_out(busy), .done_out(done), .overflow_out(ovf)
  );

  task automatic chk(input string tag,
                     input logic [79:0] obs,
                     input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (wr_en && ready) begin
        writes++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("FAIL sb_unexpected observed=%0h expected=none", wr_addr);
        end else begin
          logic [71:0] e;
          e = sb.pop_front();
          chk("wr_addr", 80'(wr_addr), 80'(e[71:64]));
          chk("wr_data", 80'(wr_data), 80'(e[63:0]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] v,
                     input logic [15:0] a, b, c, e);
    cv1 = v[0]; cv2 = v[1]; cv3 = v[2]; cv4 = v[3];
    cd1 = a; cd2 = b; cd3 = c; cd4 = e;
  endtask

  task automatic go(input logic [7:0] b, input logic [7:0] n);
    base = b;
    nrows = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int d0;
    logic seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 80'(seen), 80'(1));
    step();
    step();
    chk({tag, "_once"}, 80'(done_cnt - d0), 80'(1));
    chk({tag, "_sb"}, 80'(sb.size()), 80'(0));
  endtask

  initial begin
    int w0;
    int d0;
    logic [3:0] v;
    logic [15:0] d [4];

    // reset
    step();
    step();
    chk("rst_out", 80'({wr_en, wr_addr, wr_data, busy, done, ovf}), 80'(0));
    rst = 1'b0;
    step();

    // aligned, two rows
    ready = 1'b1;
    sb.push_back({8'h10, pk(16'd1, 16'd2, 16'd3, 16'd4)});
    sb.push_back({8'h11, 64'h0008_FFF9_0006_FFFB});
    w0 = writes;
    go(8'h10, 8'd2);
    chk("busy", 80'(busy), 80'(1));
    drv(4'hF, 16'd1, 16'd2, 16'd3, 16'd4);
    step();
    drv(4'hF, -16'sd5, 16'd6, -16'sd7, 16'd8);
    step();
    drv(4'h0, 0, 0, 0, 0);
    wait_done("aligned_done", 20);
    chk("aligned_wr", 80'(writes - w0), 80'(2));
    chk("idle_busy", 80'(busy), 80'(0));

    // skewed, three rows
    for (int r = 0; r < 3; r++) begin
      logic [7:0] h;
      h = 8'(r + 1);
      sb.push_back({8'(8'h20 + r), pk({h, 8'h01}, {h, 8'h02},
                                      {h, 8'h03}, {h, 8'h04})});
    end
    w0 = writes;
    go(8'h20, 8'd3);
    for (int c = 0; c < 7; c++) begin
      for (int k = 0; k < 4; k++) begin
        int r;
        r = c - k;
        v[k] = (r >= 0 && r <= 2);
        d[k] = {8'(r + 1), 8'(k + 1)};
      end
      drv(v, d[0], d[1], d[2], d[3]);
      step();
      if (c == 3) chk("skew_lat0", 80'(wr_en), 80'(0));
      if (c >= 4) chk("skew_en", 80'(wr_en), 80'(1));
    end
    drv(4'h0, 0, 0, 0, 0);
    wait_done("skew_done", 20);
    chk("skew_wr", 80'(writes - w0), 80'(3));

    // backpressure
    ready = 1'b0;
    sb.push_back({8'h40, pk(16'hA1, 16'hA2, 16'hA3, 16'hA4)});
    sb.push_back({8'h41, pk(16'hB1, 16'hB2, 16'hB3, 16'hB4)});
    w0 = writes;
    go(8'h40, 8'd2);
    drv(4'hF, 16'hA1, 16'hA2, 16'hA3, 16'hA4);
    step();
    drv(4'hF, 16'hB1, 16'hB2, 16'hB3, 16'hB4);
    step();
    drv(4'h0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_en", 80'(wr_en), 80'(1));
      chk("bp_addr", 80'(wr_addr), 80'(8'h40));
      chk("bp_data", 80'(wr_data),
          80'(pk(16'hA1, 16'hA2, 16'hA3, 16'hA4)));
      step();
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("bp_one", 80'(writes - w0), 80'(1));
    chk("bp_addr2", 80'(wr_addr), 80'(8'h41));
    chk("bp_data2", 80'(wr_data),
        80'(pk(16'hB1, 16'hB2, 16'hB3, 16'hB4)));
    step();
    chk("bp_hold2", 80'({wr_en, wr_addr}), 80'({1'b1, 8'h41}));
    ready = 1'b1;
    wait_done("bp_done", 20);
    chk("bp_wr", 80'(writes - w0), 80'(2));

    // overflow on column 1
    ready = 1'b0;
    for (int i = 0; i < 4; i++)
      sb.push_back({8'(8'h50 + i),
                    pk(16'(16'h11 + i), 16'(16'h21 + i),
                       16'(16'h31 + i), 16'(16'h41 + i))});
    go(8'h50, 8'd4);
    chk("ovf_clear", 80'(ovf), 80'(0));
    for (int i = 0; i < 5; i++) begin
      drv(4'b0001, 16'(16'h11 + i), 0, 0, 0);
      step();
    end
    drv(4'h0, 0, 0, 0, 0);
    chk("ovf_set", 80'(ovf), 80'(1));
    for (int i = 0; i < 4; i++) begin
      drv(4'b1110, 16'hDEAD, 16'(16'h21 + i),
          16'(16'h31 + i), 16'(16'h41 + i));
      step();
    end
    drv(4'h0, 0, 0, 0, 0);
    ready = 1'b1;
    wait_done("ovf_done", 30);
    chk("ovf_sticky", 80'(ovf), 80'(1));

    // zero-row start, also clears overflow
    w0 = writes;
    go(8'h33, 8'd0);
    chk("zero_done", 80'(done), 80'(1));
    chk("zero_ovf", 80'(ovf), 80'(0));
    step();
    chk("zero_pulse", 80'(done), 80'(0));
    step();
    chk("zero_wr", 80'(writes - w0), 80'(0));

    // address wrap
    sb.push_back({8'hFF, pk(16'h7, 16'h8, 16'h9, 16'hA)});
    sb.push_back({8'h00, pk(16'hB, 16'hC, 16'hD, 16'hE)});
    go(8'hFF, 8'd2);
    drv(4'hF, 16'h7, 16'h8, 16'h9, 16'hA);
    step();
    drv(4'hF, 16'hB, 16'hC, 16'hD, 16'hE);
    step();
    drv(4'h0, 0, 0, 0, 0);
    wait_done("wrap_done", 20);

    // reset during a stalled write
    ready = 1'b0;
    go(8'h60, 8'd2);
    drv(4'hF, 16'h1, 16'h1, 16'h1, 16'h1);
    step();
    drv(4'h0, 0, 0, 0, 0);
    step();
    chk("mid_en", 80'(wr_en), 80'(1));
    d0 = done_cnt;
    rst = 1'b1;
    step();
    chk("mid_rst", 80'({wr_en, wr_addr, wr_data, busy, done, ovf}), 80'(0));
    rst = 1'b0;
    step();
    step();
    chk("mid_nodone", 80'(done_cnt - d0), 80'(0));
    ready = 1'b1;
    sb.push_back({8'h70, pk(16'h5, 16'h6, 16'h7, 16'h8)});
    w0 = writes;
    go(8'h70, 8'd1);
    drv(4'hF, 16'h5, 16'h6, 16'h7, 16'h8);
    step();
    drv(4'h0, 0, 0, 0, 0);
    wait_done("post_rst_done", 20);
    chk("post_rst_wr", 80'(writes - w0), 80'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ub_row_writer.md
Name: ub_row_writer

Overview:
- Writeback end of the activation path. Consumes the four per-column valid/data streams leaving the leaky-ReLU stage.
- Those columns arrive skewed by the systolic array: column k trails column 1 by k-1 cycles, with possible bubbles.
- The block de-skews them in per-column FIFOs and packs each aligned set of four values into one 64-bit row.
- It writes rows to the unified buffer at consecutive addresses, using a valid/ready handshake, and reports completion.

Parameters:
- DATA_W, 16: width of each column value (signed, passed through untouched).
- FIFO_DEPTH, 4: entries per column FIFO (power of two, >= 4).
- ADDR_W, 8: unified-buffer address width; also the width of the row count.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start_in  input  1  one-cycle pulse; latches base_addr_in and num_rows_in
- base_addr_in  input  ADDR_W  first write address
- num_rows_in  input  ADDR_W  number of rows to write
- col_valid_1_in .. col_valid_4_in  input  1 each  per-column data valid
- col_data_1_in .. col_data_4_in  input  DATA_W each  per-column data (signed)
- ub_wr_en_out  output  1  write request valid
- ub_wr_addr_out  output  ADDR_W  write address
- ub_wr_data_out  output  4*DATA_W  packed row: col1 in [DATA_W-1:0], col4 in the MSBs
- ub_wr_ready_in  input  1  unified buffer accepts the write this cycle
- busy_out  output  1  high in COLLECT
- done_out  output  1  one-cycle completion pulse
- overflow_out  output  1  sticky: a column value was dropped

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0, FIFOs empty, FSM in IDLE, counters 0.
- FSM states: IDLE, COLLECT, FINISH.
- IDLE:
  - col_valid inputs are ignored and nothing is pushed.
  - On start_in with num_rows_in != 0: latch address and count, clear overflow_out, go to COLLECT.
  - On start_in with num_rows_in == 0: go to FINISH with no writes.
- COLLECT:
  - Each col_valid_k_in high pushes col_data_k_in into FIFO k at that edge.
  - start_in is ignored.
- Row formation:
  - When all four FIFOs are non-empty and the output register is free (ub_wr_en_out low, or being accepted this cycle), pop one entry from each FIFO and load the output register on the same edge.
  - Minimum latency: column-4 push at edge E gives ub_wr_en_out high after edge E+1.
  - Back-to-back rows sustain one row per cycle while ub_wr_ready_in stays high.
- Handshake:
  - While ub_wr_en_out is high, addr and data are held stable until a cycle with ub_wr_ready_in high.
  - The transfer happens on that edge. The address then increments, wrapping modulo 2^ADDR_W, and the remaining count decrements.
  - ub_wr_en_out is never withdrawn without a transfer.
- Completion:
  - The transfer of the last row moves the FSM to FINISH.
  - FINISH: done_out is high for exactly one cycle, then the FSM returns to IDLE.
  - Leftover FIFO contents are flushed on entry to IDLE.
  - A start_in arriving in FINISH is ignored.
- Overflow:
  - A push to a full FIFO with no pop on the same edge drops the value.
  - overflow_out is set and stays high until rst or the next accepted start_in.
  - Push and pop on the same edge of a full FIFO is legal and keeps its occupancy.
- Excess rows: values arriving after the last row has been loaded are dropped silently (no overflow).
- Reset mid-operation: rst in any state aborts the transfer. All outputs return to 0 on the next edge, FIFOs are emptied, and no done_out pulse is produced.

Test Plan:
- Aligned input: start with base 0x10, 2 rows. All four valids high on the same cycles with data rows {1,2,3,4} and {-5,6,-7,8}; ready tied high -> writes at 0x10 and 0x11 with data 0x0004_0003_0002_0001 and 0x0008_FFF9_0006_FFFB; then done_out pulses once.
- Skewed input: columns 1..4 valid at cycles t..t+3 for 3 rows; ready high -> first ub_wr_en_out at t+4, three consecutive writes, correct per-row packing.
- Backpressure: ready low for 5 cycles while ub_wr_en_out is high -> addr and data stable throughout; exactly one write when ready rises; no rows lost with FIFO_DEPTH 4.
- Overflow: hold ready low and push 5 values into column 1 -> overflow_out sticks at 1, and the first 4 values are written in order once the other columns fill. A new start clears overflow_out.
- Edge cases: start with num_rows_in=0 -> done_out pulses the next cycle with no write. Start with base 0xFF and 2 rows -> addresses 0xFF then 0x00.
- Reset mid-run: rst asserted during a backpressured write -> all outputs 0 after the edge, no done_out, and a fresh run afterwards behaves normally.
